// File: rtl/trng_harvester.sv
// trng_harvester: folds the 128-bit entropy pool to 32-bit words at a fixed
// decimation rate after warm-up, runs a repetition-count health test on each
// sampled word and delivers passing words over a one-deep valid/ready buffer.
module trng_harvester #(
    parameter int WARMUP    = 1024,
    parameter int DECIM     = 8,
    parameter int REP_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [127:0] pool,
    input  logic         rnd_ready,
    output logic [31:0]  rnd_data,
    output logic         rnd_valid,
    output logic         warm_done,
    output logic         health_fail,
    output logic [15:0]  drop_cnt
);

    localparam int WW = $clog2(WARMUP + 1);
    localparam int DW = $clog2(DECIM + 1);
    localparam int RW = $clog2(REP_LIMIT + 1);

    localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);
    localparam logic [DW-1:0] DEC_LAST  = DW'(DECIM - 1);
    localparam logic [RW-1:0] REP_MAX   = RW'(REP_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WARMUP  = 2'd1,
        S_COLLECT = 2'd2,
        S_FAIL    = 2'd3
    } state_t;

    // XOR-fold of the four 32-bit lanes of the pool.
    function automatic logic [31:0] fold32(input logic [127:0] p);
        return p[31:0] ^ p[63:32] ^ p[95:64] ^ p[127:96];
    endfunction

    state_t          state_r, state_s;
    logic [WW-1:0]   warm_cnt_r, warm_cnt_s;
    logic [DW-1:0]   dec_cnt_r, dec_cnt_s;
    logic [RW-1:0]   rep_cnt_r, rep_cnt_s, rep_new_s;
    logic [31:0]     prev_r, prev_s;
    logic            first_r, first_s;
    logic [31:0]     data_r, data_s;
    logic            valid_r, valid_s;
    logic [15:0]     drop_r, drop_s;
    logic            warm_done_r, health_fail_r;
    logic [31:0]     fold_s;

    // Next-state and datapath update for the harvester FSM.
    always_comb begin
        state_s    = state_r;
        warm_cnt_s = warm_cnt_r;
        dec_cnt_s  = dec_cnt_r;
        rep_cnt_s  = rep_cnt_r;
        prev_s     = prev_r;
        first_s    = first_r;
        data_s     = data_r;
        valid_s    = valid_r;
        drop_s     = drop_r;
        fold_s     = fold32(pool);

        // Repetition count this sample would produce; the first sample after
        // entering COLLECT has no predecessor to compare against.
        if (first_r) begin
            rep_new_s = RW'(1'b1);
        end else if (fold_s == prev_r) begin
            rep_new_s = rep_cnt_r + RW'(1'b1);
        end else begin
            rep_new_s = RW'(1'b1);
        end

        case (state_r)
            S_IDLE: begin
                if (enable) begin
                    state_s    = S_WARMUP;
                    warm_cnt_s = {WW{1'b0}};
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WARMUP: begin
                if (!enable) begin
                    state_s   = S_IDLE;
                    rep_cnt_s = {RW{1'b0}};
                    first_s   = 1'b1;
                end else if (warm_cnt_r == WARM_LAST) begin
                    state_s   = S_COLLECT;
                    dec_cnt_s = {DW{1'b0}};
                    rep_cnt_s = {RW{1'b0}};
                    first_s   = 1'b1;
                end else begin
                    warm_cnt_s = warm_cnt_r + WW'(1'b1);
                end
            end
            S_COLLECT: begin
                if (!enable) begin
                    // Losing enable discards the buffered word and history.
                    state_s   = S_IDLE;
                    valid_s   = 1'b0;
                    data_s    = 32'h0000_0000;
                    rep_cnt_s = {RW{1'b0}};
                    first_s   = 1'b1;
                end else begin
                    // Plain transfer; a same-edge load below overrides it.
                    if (valid_r && rnd_ready) begin
                        valid_s = 1'b0;
                    end else begin
                        valid_s = valid_r;
                    end
                    if (dec_cnt_r == DEC_LAST) begin
                        dec_cnt_s = {DW{1'b0}};
                        rep_cnt_s = rep_new_s;
                        prev_s    = fold_s;
                        first_s   = 1'b0;
                        if (rep_new_s == REP_MAX) begin
                            state_s = S_FAIL;
                            valid_s = 1'b0;
                        end else if (!valid_r || rnd_ready) begin
                            data_s  = fold_s;
                            valid_s = 1'b1;
                        end else if (drop_r != 16'hFFFF) begin
                            drop_s = drop_r + 16'd1;
                        end else begin
                            drop_s = drop_r;
                        end
                    end else begin
                        dec_cnt_s = dec_cnt_r + DW'(1'b1);
                    end
                end
            end
            S_FAIL: begin
                state_s = S_FAIL;
                valid_s = 1'b0;
            end
            default: begin
                state_s = S_IDLE;
                valid_s = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Counters, health history and the one-word output buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm_cnt_r <= {WW{1'b0}};
            dec_cnt_r  <= {DW{1'b0}};
            rep_cnt_r  <= {RW{1'b0}};
            prev_r     <= 32'h0000_0000;
            first_r    <= 1'b1;
            data_r     <= 32'h0000_0000;
            valid_r    <= 1'b0;
            drop_r     <= 16'h0000;
        end else begin
            warm_cnt_r <= warm_cnt_s;
            dec_cnt_r  <= dec_cnt_s;
            rep_cnt_r  <= rep_cnt_s;
            prev_r     <= prev_s;
            first_r    <= first_s;
            data_r     <= data_s;
            valid_r    <= valid_s;
            drop_r     <= drop_s;
        end
    end

    // Registered status flags derived from the upcoming state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            warm_done_r   <= 1'b0;
            health_fail_r <= 1'b0;
        end else begin
            warm_done_r   <= (state_s == S_COLLECT);
            health_fail_r <= (state_s == S_FAIL);
        end
    end

    assign rnd_data    = data_r;
    assign rnd_valid   = valid_r;
    assign warm_done   = warm_done_r;
    assign health_fail = health_fail_r;
    assign drop_cnt    = drop_r;

endmodule
